// File: rtl/exec_pkg.sv
// Shared result types and width helpers for the execute-to-memory collector.
package exec_pkg;

  function automatic int unsigned tag_w(input int unsigned rob_size);
    return $clog2(rob_size + 1);
  endfunction

  localparam int unsigned DataW   = 64;
  localparam int unsigned CmdW    = 10;
  localparam int unsigned RobSize = 32;
  localparam int unsigned TagW    = tag_w(RobSize);

  typedef struct packed {
    logic [DataW-1:0] val;
    logic [CmdW-1:0]  cmd;
    logic [TagW-1:0]  tag;
    logic [3:0]       flags;
  } exec_result_t;

endpackage

// File: rtl/result_fifo.sv
// Single-channel result FIFO; flush empties it and overrides push/pop in the same cycle.
module result_fifo
  import exec_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type T = exec_result_t,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  T                data_i,
  output T                data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full refuses a push even when the head leaves in the same cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever read out.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/exec_result_arbiter.sv
// N-channel execute-result collector: per-unit FIFOs drained round-robin into one registered
// output slot with valid/ready backpressure and a synchronous flush.
module exec_result_arbiter
  import exec_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = DataW,
  parameter int unsigned CMD_W      = CmdW,
  parameter int unsigned ROBsize    = RobSize,
  localparam int unsigned TAG_W = tag_w(ROBsize),
  localparam int unsigned GNT_W = $clog2(NUM_UNITS)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic [NUM_UNITS-1:0]              valid_i,
  output logic [NUM_UNITS-1:0]              canGo_o,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]  executeVal_i,
  input  logic [NUM_UNITS-1:0][CMD_W-1:0]   executeCommands_i,
  input  logic [NUM_UNITS-1:0][TAG_W-1:0]   executeTag_i,
  input  logic [NUM_UNITS-1:0][3:0]         executeFlags_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [DATA_W-1:0]                 dataToMem_o,
  output logic [CMD_W-1:0]                  commandsToMem_o,
  output logic [TAG_W-1:0]                  tagToMem_o,
  output logic [3:0]                        flagsToMem_o,
  output logic [GNT_W-1:0]                  grantUnit_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [3:0]        flags;
  } result_t;

  result_t              in_res [NUM_UNITS];
  result_t              head   [NUM_UNITS];
  logic [CntW-1:0]      count  [NUM_UNITS];
  logic [NUM_UNITS-1:0] full, empty, ne, push, pop;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_chan
    assign in_res[i]   = {executeVal_i[i], executeCommands_i[i], executeTag_i[i],
                          executeFlags_i[i]};
    assign push[i]     = valid_i[i] & ~full[i];
    assign canGo_o[i]  = (count[i] != CntW'(FIFO_DEPTH));
    assign ne[i]       = ~empty[i];

    result_fifo #(
      .Depth (FIFO_DEPTH),
      .T     (result_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (reset_i),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (in_res[i]),
      .data_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (count[i])
    );
  end

  logic [GNT_W-1:0]     rr_q, rr_d;
  logic                 valid_q, valid_d;
  result_t              slot_q, slot_d;
  logic [GNT_W-1:0]     gnt_q, gnt_d;
  logic [NUM_UNITS-1:0] mask, masked, cand;
  logic                 gnt_valid;
  logic [GNT_W-1:0]     gnt_idx;
  logic                 load;

  // Masked priority encoder: channels at or above the RR pointer first, then wrap to the rest.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      mask[i] = (i >= 32'(rr_q));
    end
    masked    = ne & mask;
    cand      = (|masked) ? masked : ne;
    gnt_valid = |ne;
    gnt_idx   = '0;
    for (int i = int'(NUM_UNITS) - 1; i >= 0; i--) begin
      if (cand[i]) gnt_idx = GNT_W'(i);
    end
  end

  assign load = ~valid_q | ready_i;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    pop     = '0;
    if (flush_i) begin
      valid_d = 1'b0;
      rr_d    = '0;
    end else if (load) begin
      if (gnt_valid) begin
        pop[gnt_idx] = 1'b1;
        slot_d       = head[gnt_idx];
        valid_d      = 1'b1;
        gnt_d        = gnt_idx;
        rr_d         = (gnt_idx == GNT_W'(NUM_UNITS - 1)) ? '0 : gnt_idx + GNT_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  assign valid_o         = valid_q;
  assign dataToMem_o     = slot_q.val;
  assign commandsToMem_o = slot_q.cmd;
  assign tagToMem_o      = slot_q.tag;
  assign flagsToMem_o    = slot_q.flags;
  assign grantUnit_o     = gnt_q;

endmodule
